// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
//   Shared constants, helpers and types for the register-file write arbiter.
//   - RF_* localparams : default geometry (data/address width, requesters,
//                        write ports) used as parameter defaults by the RTL.
//   - depth_of()       : register count for a given address width.
//   - port_asg_t       : one write port's assignment for the current cycle
//                        (valid, destination register, granted requester).
//   The struct field widths follow RF_ADDR / RF_REQ, so retargeting the
//   arbiter geometry means changing these constants, not just the module
//   parameters.
// -----------------------------------------------------------------------------
package regfile_pkg;

  localparam int RF_DATA  = 32;
  localparam int RF_ADDR  = 5;
  localparam int RF_REQ   = 4;
  localparam int RF_WRITE = 2;

  localparam int RF_DEPTH = 1 << RF_ADDR;
  localparam int RF_SRC_W = (RF_REQ > 1) ? $clog2(RF_REQ) : 1;

  function automatic int depth_of(input int addr_w);
    return 1 << addr_w;
  endfunction

  typedef struct packed {
    logic                valid;
    logic [RF_ADDR-1:0]  addr;
    logic [RF_SRC_W-1:0] src;
  } port_asg_t;

endpackage

// File: rtl/rr_port_pick.sv
// -----------------------------------------------------------------------------
// rr_port_pick
//   Combinational round-robin scan that hands out register-file write ports.
//   Requesters are visited starting at rr_ptr; each valid one is either
//   accepted as a zero-register write (no port), refused on an address clash
//   with an earlier grant, or given the lowest free port. Once every port is
//   taken the remaining requesters are refused.
//
//   Ports:
//     req_valid  in   REQ        requester has a write pending
//     req_addr   in   REQ*ADDR   destination register per requester (flat)
//     rr_ptr     in   SRC_W      first requester visited this cycle
//     block      in   1          refuse everything this cycle
//     ready      out  REQ        requester accepted this cycle
//     port_map   out  WRITE      per-port assignment (valid/addr/src)
//     any_acc    out  1          at least one requester accepted
//     last_idx   out  SRC_W      last accepted requester in scan order
// -----------------------------------------------------------------------------
module rr_port_pick
  import regfile_pkg::*;
#(
  parameter int ADDR     = RF_ADDR,
  parameter int REQ      = RF_REQ,
  parameter int WRITE    = RF_WRITE,
  parameter bit ZERO_REG = 1'b0,
  parameter int SRC_W    = RF_SRC_W
) (
  input  logic [REQ-1:0]      req_valid,
  input  logic [REQ*ADDR-1:0] req_addr,
  input  logic [SRC_W-1:0]    rr_ptr,
  input  logic                block,
  output logic [REQ-1:0]      ready,
  output port_asg_t [WRITE-1:0] port_map,
  output logic                any_acc,
  output logic [SRC_W-1:0]    last_idx
);

  logic [REQ-1:0][ADDR-1:0] addr_a;
  assign addr_a = req_addr;

  logic [SRC_W:0]   sum;
  logic [SRC_W-1:0] idx;
  logic             conflict;
  logic             placed;

  // NOTE: every variable written here gets a default before the scan, so no
  // path through the loop leaves a value unassigned and no latch is inferred.
  always_comb begin
    ready    = '0;
    port_map = '0;
    any_acc  = 1'b0;
    last_idx = '0;
    sum      = '0;
    idx      = '0;
    conflict = 1'b0;
    placed   = 1'b0;

    for (int k = 0; k < REQ; k++) begin
      // Rotate: idx = (rr_ptr + k) mod REQ without a divider.
      sum = {1'b0, rr_ptr} + (SRC_W+1)'(k);
      if (sum >= (SRC_W+1)'(REQ)) sum = sum - (SRC_W+1)'(REQ);
      idx = sum[SRC_W-1:0];

      // Ports fill from 0 upward, so the last port being taken means full.
      if (!block && req_valid[idx] && !port_map[WRITE-1].valid) begin
        if (ZERO_REG && addr_a[idx] == '0) begin
          ready[idx] = 1'b1;
          any_acc    = 1'b1;
          last_idx   = idx;
        end else begin
          conflict = 1'b0;
          for (int p = 0; p < WRITE; p++)
            if (port_map[p].valid && port_map[p].addr == addr_a[idx])
              conflict = 1'b1;

          if (!conflict) begin
            placed = 1'b0;
            for (int p = 0; p < WRITE; p++) begin
              if (!placed && !port_map[p].valid) begin
                port_map[p].valid = 1'b1;
                port_map[p].addr  = addr_a[idx];
                port_map[p].src   = idx;
                placed            = 1'b1;
              end
            end
            ready[idx] = 1'b1;
            any_acc    = 1'b1;
            last_idx   = idx;
          end
        end
      end
    end
  end

endmodule

// File: rtl/regfile_wr_arb.sv
// -----------------------------------------------------------------------------
// regfile_wr_arb
//   Shares WRITE register-file write ports among REQ producers. Grants come
//   from a round-robin scan (rr_port_pick) and are registered straight onto
//   the register file's active-low write bus. A pending-write bitmap marks
//   registers whose write currently sits in the output stage.
//
//   Ports:
//     clk        in   1           clock
//     reset      in   1           synchronous active-high reset
//     req_valid  in   REQ         requester has a write pending
//     req_addr   in   REQ*ADDR    destination register per requester (flat)
//     req_data   in   REQ*DATA    write data per requester (flat)
//     req_ready  out  REQ         write accepted this cycle (combinational)
//     stall      in   1           blocks all grants this cycle
//     wr_waddr   out  WRITE*ADDR  register-file write address (registered)
//     wr_we_     out  WRITE       register-file write enable, active-low
//     wr_wdata   out  WRITE*DATA  register-file write data (registered)
//     pend       out  DEPTH       bit a set = write to register a in flight
// -----------------------------------------------------------------------------
module regfile_wr_arb
  import regfile_pkg::*;
#(
  parameter int DATA     = RF_DATA,
  parameter int ADDR     = RF_ADDR,
  parameter int REQ      = RF_REQ,
  parameter int WRITE    = RF_WRITE,
  parameter bit ZERO_REG = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REQ-1:0]        req_valid,
  input  logic [REQ*ADDR-1:0]   req_addr,
  input  logic [REQ*DATA-1:0]   req_data,
  output logic [REQ-1:0]        req_ready,
  input  logic                  stall,
  output logic [WRITE*ADDR-1:0] wr_waddr,
  output logic [WRITE-1:0]      wr_we_,
  output logic [WRITE*DATA-1:0] wr_wdata,
  output logic [depth_of(ADDR)-1:0] pend
);

  localparam int DEPTH = depth_of(ADDR);
  localparam int SRC_W = (REQ > 1) ? $clog2(REQ) : 1;

  logic [SRC_W-1:0]           rr_ptr;
  logic [REQ-1:0]             pick_ready;
  port_asg_t [WRITE-1:0]      port_map;
  logic                       any_acc;
  logic [SRC_W-1:0]           last_idx;
  logic [DEPTH-1:0]           pend_nxt;
  logic [REQ-1:0][DATA-1:0]   data_a;

  assign data_a = req_data;

  // Reset also blocks the scan, so nothing is granted or advanced under reset.
  rr_port_pick #(
    .ADDR     (ADDR),
    .REQ      (REQ),
    .WRITE    (WRITE),
    .ZERO_REG (ZERO_REG),
    .SRC_W    (SRC_W)
  ) u_pick (
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .rr_ptr    (rr_ptr),
    .block     (stall | reset),
    .ready     (pick_ready),
    .port_map  (port_map),
    .any_acc   (any_acc),
    .last_idx  (last_idx)
  );

  assign req_ready = pick_ready & {REQ{~reset}};

  always_comb begin
    pend_nxt = '0;
    for (int p = 0; p < WRITE; p++)
      if (port_map[p].valid) pend_nxt[port_map[p].addr] = 1'b1;
    if (ZERO_REG) pend_nxt[0] = 1'b0;
  end

  // NOTE: all state here is updated with non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr   <= '0;
      wr_we_   <= '1;
      wr_waddr <= '0;
      wr_wdata <= '0;
      pend     <= '0;
    end else begin
      if (any_acc)
        rr_ptr <= (last_idx == SRC_W'(REQ-1)) ? '0 : last_idx + 1'b1;

      // Unassigned ports go idle but keep their last address/data.
      for (int p = 0; p < WRITE; p++) begin
        if (port_map[p].valid) begin
          wr_we_[p]                   <= 1'b0;
          wr_waddr[p*ADDR +: ADDR]    <= port_map[p].addr;
          wr_wdata[p*DATA +: DATA]    <= data_a[port_map[p].src];
        end else begin
          wr_we_[p] <= 1'b1;
        end
      end

      pend <= pend_nxt;
    end
  end

endmodule
